// File: rtl/univ_reg.sv
// Universal register: hold, parallel load, shift, rotate, increment and decrement.
// Every operation completes in one cycle; there is no backpressure, and en=0 simply freezes q and cout.
module univ_reg #(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             zero
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic             r_cout;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_cout_nxt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;

  // One extra bit catches the wrap; it only ever reaches cout, never q.
  assign w_sum  = {1'b0, r_q} + {{WIDTH{1'b0}}, 1'b1};
  assign w_diff = {1'b0, r_q} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    w_q_nxt    = r_q;
    w_cout_nxt = r_cout;
    case (mode)
      MODE_HOLD: begin
        w_q_nxt    = r_q;
        w_cout_nxt = r_cout;
      end
      MODE_LOAD: begin
        w_q_nxt    = d;
        w_cout_nxt = 1'b0;
      end
      MODE_SHL: begin
        w_q_nxt    = {r_q[WIDTH-2:0], sin_r};
        w_cout_nxt = r_q[WIDTH-1];
      end
      MODE_SHR: begin
        w_q_nxt    = {sin_l, r_q[WIDTH-1:1]};
        w_cout_nxt = r_q[0];
      end
      MODE_ROL: begin
        w_q_nxt    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_cout_nxt = r_q[WIDTH-1];
      end
      MODE_ROR: begin
        w_q_nxt    = {r_q[0], r_q[WIDTH-1:1]};
        w_cout_nxt = r_q[0];
      end
      MODE_INC: begin
        w_q_nxt    = w_sum[WIDTH-1:0];
        w_cout_nxt = w_sum[WIDTH];
      end
      MODE_DEC: begin
        w_q_nxt    = w_diff[WIDTH-1:0];
        w_cout_nxt = w_diff[WIDTH];
      end
      default: begin
        w_q_nxt    = r_q;
        w_cout_nxt = r_cout;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q    <= RESET_VAL;
      r_cout <= 1'b0;
    end else if (en) begin
      r_q    <= w_q_nxt;
      r_cout <= w_cout_nxt;
    end
  end

  assign q    = r_q;
  assign cout = r_cout;
  assign zero = (r_q == '0);

endmodule

// File: doc/univ_reg.md
UNIV_REG -- requirements
Module: univ_reg

Interface
REQ-001 The block SHALL take parameter WIDTH, default 4: register width in bits; legal values are WIDTH >= 2.
REQ-002 The block SHALL take parameter RESET_VAL, default 0: the WIDTH-bit value loaded into q on reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port clr, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: operation enable.
REQ-006 The block SHALL have port mode, input, 3 bits: operation select.
REQ-007 The block SHALL have port d, input, WIDTH bits: parallel load data.
REQ-008 The block SHALL have port sin_r, input, 1 bit: serial-in bit entering the LSB on a left shift.
REQ-009 The block SHALL have port sin_l, input, 1 bit: serial-in bit entering the MSB on a right shift.
REQ-010 The block SHALL have port q, output, WIDTH bits: register contents.
REQ-011 The block SHALL have port cout, output, 1 bit: registered shift-out, carry or borrow.
REQ-012 The block SHALL have port zero, output, 1 bit: high when q is all zeros.

Function
REQ-013 On a rising clk edge with clr=1, the block SHALL set q to RESET_VAL and cout to 0, regardless of en, mode and d.
REQ-014 On a rising clk edge with clr=0 and en=0, the block SHALL hold q and cout unchanged.
REQ-015 On a rising clk edge with clr=0 and en=1, the block SHALL update q and cout per mode as given in REQ-016 to REQ-023; every operation has single-cycle latency.
REQ-016 mode 000 (HOLD) SHALL leave q and cout unchanged.
REQ-017 mode 001 (LOAD) SHALL set q to d and cout to 0.
REQ-018 mode 010 (SHL) SHALL set q to {q[WIDTH-2:0], sin_r} and cout to the old q[WIDTH-1].
REQ-019 mode 011 (SHR) SHALL set q to {sin_l, q[WIDTH-1:1]} and cout to the old q[0].
REQ-020 mode 100 (ROL) SHALL set q to {q[WIDTH-2:0], q[WIDTH-1]} and cout to the old q[WIDTH-1]; sin_r is ignored.
REQ-021 mode 101 (ROR) SHALL set q to {q[0], q[WIDTH-1:1]} and cout to the old q[0]; sin_l is ignored.
REQ-022 mode 110 (INC) SHALL set q to (q+1) mod 2^WIDTH, with cout=1 only on wrap from all-ones to zero and cout=0 otherwise.
REQ-023 mode 111 (DEC) SHALL set q to (q-1) mod 2^WIDTH, with cout=1 only on wrap from zero to all-ones and cout=0 otherwise.
REQ-024 zero SHALL be combinational from q (zero = (q == 0)), with no added latency.
REQ-025 Arithmetic SHALL be unsigned and WIDTH bits wide; the carry/borrow appears only on cout and is never stored in q.
REQ-026 Inputs d, sin_l and sin_r SHALL be sampled only on the edge where they are used; their value on other edges SHALL have no effect.
REQ-027 The block SHALL contain no internal state other than q and cout; there are no multi-cycle operations and nothing for a reset to abort.

Reset
REQ-028 clr SHALL take priority over en and every mode, including when asserted in the same cycle as LOAD, INC or DEC.
REQ-029 After reset, outputs SHALL be q=RESET_VAL, cout=0, and zero=1 when RESET_VAL=0.
REQ-030 Before the first clr, q and cout are unspecified; the bench SHALL apply clr for at least 1 cycle before checking any output.
REQ-031 The first operation after clr deasserts SHALL execute on the first rising edge with clr=0 and en=1.

Verification (WIDTH=4, RESET_VAL=0)
REQ-032 Bench SHALL check: clr=1, en=1, mode=LOAD, d=1010 for 1 cycle -> q=0000, cout=0, zero=1.
REQ-033 Bench SHALL check: LOAD 0101, then SHL with sin_r=1 -> q=1011, cout=0; then SHL with sin_r=0 -> q=0110, cout=1.
REQ-034 Bench SHALL check: LOAD 0001, then ROR x4 -> q = 1000, 0100, 0010, 0001 with cout = 1, 0, 0, 0.
REQ-035 Bench SHALL check: LOAD 1110, then INC x2 -> q=1111 with cout=0, then q=0000 with cout=1 and zero=1.
REQ-036 Bench SHALL check: from q=0000, DEC -> q=1111, cout=1; then en=0 with mode=INC for 3 cycles -> q=1111 and cout=1 throughout.
REQ-037 Bench SHALL check: loop LOAD of d = 0000..1111 twice, one value per cycle, then clr asserted mid-sequence -> q equals the prior d one cycle after each LOAD, and q=0000 on the clr edge.
